// File: rtl/sdp_fifo_ctrl_pkg.sv
// ============================================================================
// Module  : sdp_fifo_ctrl_pkg
// Brief   : Shared defaults and a depth helper for the SDP FIFO controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sdp_fifo_ctrl_pkg;

   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_ADDR_WIDTH = 4;

   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sdp_fifo_ctrl_if.sv
// ============================================================================
// Module  : sdp_fifo_ctrl_if
// Brief   : Stream-in, stream-out and RAM-port bundle of the SDP FIFO controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdp_fifo_ctrl_if
   import sdp_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH+1:0] count;
   logic                  ram_wenable;
   logic [ADDR_WIDTH-1:0] ram_waddr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic                  ram_renable;
   logic [ADDR_WIDTH-1:0] ram_raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   // Controller side
   modport slave (
      input  in_valid, in_data, out_ready, ram_rdata,
      output in_ready, out_valid, out_data, count,
             ram_wenable, ram_waddr, ram_wdata, ram_renable, ram_raddr
   );

   // Producer / consumer / RAM side
   modport master (
      output in_valid, in_data, out_ready, ram_rdata,
      input  in_ready, out_valid, out_data, count,
             ram_wenable, ram_waddr, ram_wdata, ram_renable, ram_raddr
   );

endinterface

`default_nettype wire

// File: rtl/sdp_fifo_ctrl_ptr.sv
// ============================================================================
// Module  : sdp_fifo_ctrl_ptr
// Brief   : Wrapping FIFO pointer (fifo_ptr) with increment enable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_fifo_ctrl_ptr #(
   parameter int WIDTH = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc_i,
   output logic [WIDTH-1:0] ptr_o
);

   logic [WIDTH-1:0] ptr_q;
   logic [WIDTH-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q + WIDTH'(inc_i);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/simple_dual_port_ram_reg1.sv
// ============================================================================
// Module  : simple_dual_port_ram_reg1
// Brief   : Simple dual-port RAM, one write port, one read port with 1-cycle
//           registered read data that holds while renable is low.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_dual_port_ram_reg1 #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  wenable,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  renable,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (wenable) begin
         mem_q[waddr] <= wdata;
      end
      if (renable) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sdp_fifo_ctrl.sv
// ============================================================================
// Module  : sdp_fifo_ctrl
// Brief   : FWFT FIFO controller driving an external registered-read SDP RAM;
//           the RAM read register acts as the output stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_fifo_ctrl
   import sdp_fifo_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic           clock,
   input  logic           reset,
   sdp_fifo_ctrl_if.slave bus
);

   localparam int                   PTR_WIDTH = ADDR_WIDTH + 1;
   localparam logic [PTR_WIDTH-1:0] c_DEPTH   = PTR_WIDTH'(fifo_depth(ADDR_WIDTH));

   logic [PTR_WIDTH-1:0] w_wptr;
   logic [PTR_WIDTH-1:0] w_rptr;
   logic [PTR_WIDTH-1:0] w_ram_count;
   logic                 w_ram_full;
   logic                 w_ram_empty;
   logic                 w_in_ready;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_load;
   logic                 out_valid_q;
   logic                 out_valid_d;

   sdp_fifo_ctrl_ptr #(
      .WIDTH (PTR_WIDTH)
   ) u_wptr (
      .clock (clock),
      .reset (reset),
      .inc_i (w_push),
      .ptr_o (w_wptr)
   );

   sdp_fifo_ctrl_ptr #(
      .WIDTH (PTR_WIDTH)
   ) u_rptr (
      .clock (clock),
      .reset (reset),
      .inc_i (w_load),
      .ptr_o (w_rptr)
   );

   // Registered wptr in ram_empty keeps a word from being read in its write cycle
   always_comb begin
      w_ram_count = w_wptr - w_rptr;
      w_ram_full  = (w_ram_count == c_DEPTH);
      w_ram_empty = (w_ram_count == '0);
      w_in_ready  = ~reset & ~w_ram_full;
      w_push      = bus.in_valid & w_in_ready;
      w_pop       = out_valid_q & bus.out_ready;
      w_load      = ~w_ram_empty & (~out_valid_q | bus.out_ready) & ~reset;
   end

   always_comb begin
      out_valid_d = out_valid_q;
      if (w_load) begin
         out_valid_d = 1'b1;
      end else if (w_pop) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = bus.ram_rdata;
   assign bus.count       = {1'b0, w_ram_count} + {{PTR_WIDTH{1'b0}}, out_valid_q};
   assign bus.ram_wenable = w_push;
   assign bus.ram_waddr   = w_wptr[ADDR_WIDTH-1:0];
   assign bus.ram_wdata   = bus.in_data;
   assign bus.ram_renable = w_load;
   assign bus.ram_raddr   = w_rptr[ADDR_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_sdp_fifo_ctrl.sv
// ============================================================================
// Module  : tb_sdp_fifo_ctrl
// Brief   : Directed self-checking bench for sdp_fifo_ctrl with its SDP RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdp_fifo_ctrl;

   localparam int DW = 8;
   localparam int AW = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clock = ~clock;

   sdp_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   sdp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   simple_dual_port_ram_reg1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ram (
      .clock   (clock),
      .wenable (bus.ram_wenable),
      .waddr   (bus.ram_waddr),
      .wdata   (bus.ram_wdata),
      .renable (bus.ram_renable),
      .raddr   (bus.ram_raddr),
      .rdata   (bus.ram_rdata)
   );

   // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      bus.in_valid = 1'b1;
      bus.in_data = 8'hEE;
      #1;
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b exp 0", bus.in_ready); end
      n_tests++; if (bus.ram_wenable !== 1'b0) begin n_fail++; $display("FAIL reset_wenable: got %b exp 0", bus.ram_wenable); end
      n_tests++; if (bus.ram_renable !== 1'b0) begin n_fail++; $display("FAIL reset_renable: got %b exp 0", bus.ram_renable); end
      n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", bus.count); end
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
      tick();
      reset = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_release_count: got %0d exp 0", bus.count); end
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b exp 1", bus.in_ready); end
   endtask

   task automatic test_single();
      tick();
      bus.in_valid = 1'b1;
      bus.in_data = 8'hA5;
      bus.out_ready = 1'b1;
      #1;
      n_tests++; if (bus.ram_wenable !== 1'b1) begin n_fail++; $display("FAIL single_wenable: got %b exp 1", bus.ram_wenable); end
      n_tests++; if (bus.ram_waddr !== 2'd0) begin n_fail++; $display("FAIL single_waddr: got %0d exp 0", bus.ram_waddr); end
      n_tests++; if (bus.ram_wdata !== 8'hA5) begin n_fail++; $display("FAIL single_wdata: got %h exp a5", bus.ram_wdata); end
      tick();
      bus.in_valid = 1'b0;
      #1;
      n_tests++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL single_count_c1: got %0d exp 1", bus.count); end
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_out_valid_c1: got %b exp 0", bus.out_valid); end
      n_tests++; if (bus.ram_renable !== 1'b1) begin n_fail++; $display("FAIL single_renable_c1: got %b exp 1", bus.ram_renable); end
      tick();
      #1;
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid_c2: got %b exp 1", bus.out_valid); end
      n_tests++; if (bus.out_data !== 8'hA5) begin n_fail++; $display("FAIL single_out_data_c2: got %h exp a5", bus.out_data); end
      n_tests++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL single_count_c2: got %0d exp 1", bus.count); end
      tick();
      #1;
      n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL single_count_c3: got %0d exp 0", bus.count); end
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_out_valid_c3: got %b exp 0", bus.out_valid); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 6; i++) begin
         tick();
         bus.in_valid = 1'b1;
         bus.in_data = 8'(i);
         bus.out_ready = 1'b0;
         #1;
         n_tests++;
         if (bus.in_ready !== (i <= 5)) begin
            n_fail++; $display("FAIL fill_in_ready_%0d: got %b exp %b", i, bus.in_ready, (i <= 5));
         end
      end
      n_tests++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL fill_count_full: got %0d exp 5", bus.count); end
      tick();
      #1;
      n_tests++; if (bus.in_ready !== 1'b0 || bus.count !== 4'd5) begin
         n_fail++; $display("FAIL fill_hold: in_ready %b count %0d exp 0 5", bus.in_ready, bus.count);
      end
      for (int j = 1; j <= 5; j++) begin
         tick();
         bus.in_valid = 1'b0;
         bus.out_ready = 1'b1;
         #1;
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 8'(j)) begin
            n_fail++; $display("FAIL fill_drain_%0d: valid %b data %h exp 1 %h", j, bus.out_valid, bus.out_data, 8'(j));
         end
      end
      tick();
      bus.out_ready = 1'b0;
      #1;
      n_tests++; if (bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin
         n_fail++; $display("FAIL fill_empty: valid %b count %0d exp 0 0", bus.out_valid, bus.count);
      end
   endtask

   task automatic test_full_pop();
      for (int i = 0; i < 5; i++) begin
         tick();
         bus.in_valid = 1'b1;
         bus.in_data = 8'h10 + 8'(i);
         #1;
      end
      tick();
      bus.in_data = 8'h15;
      bus.out_ready = 1'b1;
      #1;
      n_tests++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL fullpop_count5: got %0d exp 5", bus.count); end
      n_tests++; if (bus.in_ready !== 1'b0 || bus.ram_wenable !== 1'b0) begin
         n_fail++; $display("FAIL fullpop_no_push: in_ready %b wenable %b exp 0 0", bus.in_ready, bus.ram_wenable);
      end
      tick();
      bus.out_ready = 1'b0;
      #1;
      n_tests++; if (bus.count !== 4'd4) begin n_fail++; $display("FAIL fullpop_count4: got %0d exp 4", bus.count); end
      n_tests++; if (bus.in_ready !== 1'b1 || bus.ram_wenable !== 1'b1) begin
         n_fail++; $display("FAIL fullpop_push: in_ready %b wenable %b exp 1 1", bus.in_ready, bus.ram_wenable);
      end
      tick();
      bus.in_valid = 1'b0;
      #1;
      n_tests++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL fullpop_count5b: got %0d exp 5", bus.count); end
      for (int j = 1; j <= 5; j++) begin
         tick();
         bus.out_ready = 1'b1;
         #1;
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h10 + 8'(j)) begin
            n_fail++; $display("FAIL fullpop_drain_%0d: valid %b data %h exp 1 %h", j, bus.out_valid, bus.out_data, 8'h10 + 8'(j));
         end
      end
      tick();
      bus.out_ready = 1'b0;
      #1;
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_wrap();
      int          sent;
      int          recv;
      int unsigned seed_val;
      sent = 0;
      recv = 0;
      seed_val = $urandom(32'd2024);
      for (int cyc = 0; cyc < 400 && recv < 20; cyc++) begin
         tick();
         bus.in_valid = (sent < 20) && ($urandom_range(1, 0) == 1);
         bus.in_data = 8'(sent);
         bus.out_ready = ($urandom_range(1, 0) == 1);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            n_tests++;
            if (bus.out_data !== 8'(recv)) begin
               n_fail++; $display("FAIL wrap_word_%0d: got %h exp %h", recv, bus.out_data, 8'(recv));
            end
            recv++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
      end
      n_tests++; if (recv != 20) begin n_fail++; $display("FAIL wrap_timeout: got %0d words exp 20 (seed %0d)", recv, seed_val); end
      tick();
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      n_tests++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL wrap_empty_count: got %0d exp 0", bus.count); end
   endtask

   task automatic test_backpressure();
      int nxt;
      nxt = 8'h30;
      for (int c = 0; c < 12; c++) begin
         tick();
         bus.in_valid = 1'b1;
         bus.in_data = 8'(nxt);
         bus.out_ready = 1'b0;
         #1;
         if (c >= 2) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h30 || bus.ram_renable !== 1'b0) begin
               n_fail++; $display("FAIL bp_hold_%0d: valid %b data %h renable %b exp 1 30 0", c, bus.out_valid, bus.out_data, bus.ram_renable);
            end
         end
         if (bus.in_valid && bus.in_ready) nxt++;
      end
      n_tests++; if (nxt != 8'h35) begin n_fail++; $display("FAIL bp_accepted: got %h exp 35", nxt); end
      for (int j = 0; j < 5; j++) begin
         tick();
         bus.in_valid = 1'b0;
         bus.out_ready = 1'b1;
         #1;
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h30 + 8'(j)) begin
            n_fail++; $display("FAIL bp_drain_%0d: valid %b data %h exp 1 %h", j, bus.out_valid, bus.out_data, 8'h30 + 8'(j));
         end
      end
      tick();
      bus.out_ready = 1'b0;
      #1;
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         tick();
         bus.in_valid = 1'b1;
         bus.in_data = 8'hA1 + 8'(i);
         bus.out_ready = 1'b0;
         #1;
      end
      tick();
      bus.in_valid = 1'b0;
      #1;
      n_tests++; if (bus.count !== 4'd3) begin n_fail++; $display("FAIL rmid_count3: got %0d exp 3", bus.count); end
      tick();
      reset = 1'b1;
      #1;
      n_tests++; if (bus.in_ready !== 1'b0 || bus.ram_renable !== 1'b0 || bus.out_valid !== 1'b1) begin
         n_fail++; $display("FAIL rmid_during: in_ready %b renable %b valid %b exp 0 0 1", bus.in_ready, bus.ram_renable, bus.out_valid);
      end
      tick();
      reset = 1'b0;
      #1;
      n_tests++; if (bus.count !== 4'd0 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rmid_after: count %0d valid %b exp 0 0", bus.count, bus.out_valid);
      end
      tick();
      bus.in_valid = 1'b1;
      bus.in_data = 8'h55;
      bus.out_ready = 1'b1;
      #1;
      n_tests++; if (bus.ram_waddr !== 2'd0 || bus.ram_wenable !== 1'b1) begin
         n_fail++; $display("FAIL rmid_push: waddr %0d wenable %b exp 0 1", bus.ram_waddr, bus.ram_wenable);
      end
      tick();
      bus.in_valid = 1'b0;
      #1;
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_stale: got %b exp 0", bus.out_valid); end
      tick();
      #1;
      n_tests++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55) begin
         n_fail++; $display("FAIL rmid_word: valid %b data %h exp 1 55", bus.out_valid, bus.out_data);
      end
      tick();
      bus.out_ready = 1'b0;
      #1;
      n_tests++; if (bus.out_valid !== 1'b0 || bus.count !== 4'd0) begin
         n_fail++; $display("FAIL rmid_end: valid %b count %0d exp 0 0", bus.out_valid, bus.count);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_full_pop();
      test_wrap();
      test_backpressure();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
